cpu_mem_bridge: RTL and testbench

CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

---
 rtl/cpu_mem_bridge_pkg.sv | 27 ++
 rtl/cpu_mem_bridge_if.sv | 41 ++++
 rtl/cpu_mem_bridge_watchdog.sv | 23 ++
 rtl/cpu_mem_bridge.sv | 96 +++++++++
 tb/tb_cpu_mem_bridge.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_bridge_pkg.sv
// Shared types for the CPU-to-memory bridge: FSM encoding, request kinds,
// the latched request record and a saturating counter helper.
package cpu_mem_bridge_pkg;

  typedef logic [1:0] kind_t;
  localparam kind_t FETCH = 2'd0;
  localparam kind_t LOAD  = 2'd1;
  localparam kind_t STORE = 2'd2;

  localparam logic [4:0] IDLE = 5'b00001;
  localparam logic [4:0] ACPT = 5'b00010;
  localparam logic [4:0] MREQ = 5'b00100;
  localparam logic [4:0] MRSP = 5'b01000;
  localparam logic [4:0] RESP = 5'b10000;

  typedef struct packed {
    kind_t       kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_mem_bridge_if.sv
// CPU-side (fetch + load/store) and memory-side bus bundles for the bridge.
interface cpu_bus_if;
  logic [31:0] PC;
  logic        Inst_Req_Valid, Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid, Inst_Ready;
  logic [31:0] Address, Write_data, Read_data;
  logic [3:0]  Write_strb;
  logic        MemWrite, MemRead, Mem_Req_Ready;
  logic        Read_data_Valid, Read_data_Ready;

  modport master (
    output PC, Inst_Req_Valid, Inst_Ready, Address, MemWrite, Write_data,
           Write_strb, MemRead, Read_data_Ready,
    input  Inst_Req_Ready, Instruction, Inst_Valid, Mem_Req_Ready, Read_data,
           Read_data_Valid
  );
  modport slave (
    input  PC, Inst_Req_Valid, Inst_Ready, Address, MemWrite, Write_data,
           Write_strb, MemRead, Read_data_Ready,
    output Inst_Req_Ready, Instruction, Inst_Valid, Mem_Req_Ready, Read_data,
           Read_data_Valid
  );
endinterface

interface mem_bus_if;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;

  modport master (
    output mem_req_valid, mem_addr, mem_wdata, mem_we, mem_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );
  modport slave (
    input  mem_req_valid, mem_addr, mem_wdata, mem_we, mem_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/cpu_mem_bridge_watchdog.sv
// Latency watchdog: counts enabled cycles and flags the cycle that reaches limit.
module bridge_watchdog #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         expire
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt <= '0;
    else if (clear)                  cnt <= '0;
    else if (enable && cnt != limit) cnt <= cnt + W'(1);
  end

  // Stays high once reached, so a late memory handshake cannot outrun it.
  assign expire = enable && (({1'b0, cnt} + {{W{1'b0}}, 1'b1}) >= {1'b0, limit});

endmodule

// File: rtl/cpu_mem_bridge.sv
// Single-outstanding bridge from CPU fetch/load/store ports to a simple memory bus.
module cpu_mem_bridge
  import cpu_mem_bridge_pkg::*;
#(
  parameter int MEM_LAT_MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  cpu_bus_if.slave     cpu,
  mem_bus_if.master    mem,
  output logic         bus_err,
  output logic [31:0]  err_cnt
);
  localparam int              WD_W     = $clog2(MEM_LAT_MAX + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MEM_LAT_MAX);

  logic [4:0]  state;
  req_t        req_q;
  logic [31:0] data_q;
  logic        wd_en, wd_expire, timeout;
  logic        inst_vld, rd_vld, rsp_hs;

  assign wd_en = (state == MREQ) || (state == MRSP);

  bridge_watchdog #(.W(WD_W)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .enable (wd_en),
    .clear  (!wd_en),
    .limit  (WD_LIMIT),
    .expire (wd_expire)
  );

  // A completed handshake in the expiring cycle wins over the timeout.
  assign timeout = wd_expire
                 && !((state == MREQ) && mem.mem_req_ready)
                 && !((state == MRSP) && mem.mem_rsp_valid);

  assign inst_vld = (state == RESP) && (req_q.kind == FETCH);
  assign rd_vld   = (state == RESP) && (req_q.kind == LOAD);
  assign rsp_hs   = (inst_vld && cpu.Inst_Ready) || (rd_vld && cpu.Read_data_Ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      req_q   <= '0;
      data_q  <= '0;
      bus_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu.MemRead || cpu.MemWrite) begin
            req_q <= '{kind:  cpu.MemWrite ? STORE : LOAD,
                       addr:  cpu.Address,
                       wdata: cpu.Write_data,
                       wstrb: cpu.Write_strb};
            state <= ACPT;
          end else if (cpu.Inst_Req_Valid) begin
            req_q <= '{kind: FETCH, addr: cpu.PC, wdata: '0, wstrb: '0};
            state <= ACPT;
          end
        end
        ACPT: state <= MREQ;
        MREQ: if (mem.mem_req_ready) state <= (req_q.kind == STORE) ? IDLE : MRSP;
        MRSP: if (mem.mem_rsp_valid) begin
          data_q <= mem.mem_rdata;
          state  <= RESP;
        end
        RESP:    if (rsp_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
      // A timed-out store has no CPU response to deliver, so it just retires.
      if (timeout) begin
        bus_err <= 1'b1;
        err_cnt <= sat_inc(err_cnt);
        data_q  <= '0;
        state   <= (req_q.kind == STORE) ? IDLE : RESP;
      end
    end
  end

  assign cpu.Inst_Req_Ready  = (state == ACPT) && (req_q.kind == FETCH);
  assign cpu.Mem_Req_Ready   = (state == ACPT) && (req_q.kind != FETCH);
  assign cpu.Inst_Valid      = inst_vld;
  assign cpu.Read_data_Valid = rd_vld;
  assign cpu.Instruction     = data_q;
  assign cpu.Read_data       = data_q;

  assign mem.mem_req_valid = (state == MREQ);
  assign mem.mem_addr      = req_q.addr;
  assign mem.mem_wdata     = req_q.wdata;
  assign mem.mem_wstrb     = req_q.wstrb;
  assign mem.mem_we        = (req_q.kind == STORE);

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench: fetch, store, contention, backpressure, timeout, reset mid-read.
module tb_cpu_mem_bridge;
  import cpu_mem_bridge_pkg::*;

  logic clk, rst;
  cpu_bus_if cpu0();
  mem_bus_if mem0();
  cpu_bus_if cpu1();
  mem_bus_if mem1();
  logic        bus_err0, bus_err1;
  logic [31:0] err_cnt0, err_cnt1;

  cpu_mem_bridge u_dut (
    .clk(clk), .rst(rst), .cpu(cpu0), .mem(mem0), .bus_err(bus_err0), .err_cnt(err_cnt0)
  );
  cpu_mem_bridge #(.MEM_LAT_MAX(8)) u_dut8 (
    .clk(clk), .rst(rst), .cpu(cpu1), .mem(mem1), .bus_err(bus_err1), .err_cnt(err_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory model for dut0: answers reads one cycle after acceptance, logs writes.
  logic        rsp_en;
  logic [31:0] rsp_word;
  int          wr_cnt, mem_hs, cpu_rd_hs;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  always @(negedge clk) begin
    if (rst && mem0.mem_req_valid && mem0.mem_req_ready) mem_hs++;
    if (rst && cpu0.Read_data_Valid && cpu0.Read_data_Ready) cpu_rd_hs++;
  end

  always @(negedge clk) begin
    if (rst && mem0.mem_req_valid && mem0.mem_req_ready) begin
      if (mem0.mem_we) begin
        wr_cnt++;
        wr_addr = mem0.mem_addr;
        wr_data = mem0.mem_wdata;
        wr_strb = mem0.mem_wstrb;
      end else if (rsp_en) begin
        @(posedge clk); #1;
        mem0.mem_rsp_valid = 1'b1;
        mem0.mem_rdata     = rsp_word;
        @(posedge clk); #1;
        mem0.mem_rsp_valid = 1'b0;
      end
    end
  end

  int n;

  initial begin
    rst = 1'b0;
    rsp_en = 1'b1; rsp_word = '0; wr_cnt = 0; mem_hs = 0; cpu_rd_hs = 0;
    wr_addr = '0; wr_data = '0; wr_strb = '0;
    cpu0.PC = '0; cpu0.Inst_Req_Valid = 0; cpu0.Inst_Ready = 0; cpu0.Address = '0;
    cpu0.MemWrite = 0; cpu0.Write_data = '0; cpu0.Write_strb = '0; cpu0.MemRead = 0;
    cpu0.Read_data_Ready = 0;
    mem0.mem_req_ready = 0; mem0.mem_rsp_valid = 0; mem0.mem_rdata = '0;
    cpu1.PC = '0; cpu1.Inst_Req_Valid = 0; cpu1.Inst_Ready = 0; cpu1.Address = '0;
    cpu1.MemWrite = 0; cpu1.Write_data = '0; cpu1.Write_strb = '0; cpu1.MemRead = 0;
    cpu1.Read_data_Ready = 0;
    mem1.mem_req_ready = 1; mem1.mem_rsp_valid = 0; mem1.mem_rdata = '0;

    // Reset values
    step(3);
    chk("rst_ctl", 32'({cpu0.Inst_Req_Ready, cpu0.Mem_Req_Ready, cpu0.Inst_Valid,
                        cpu0.Read_data_Valid, mem0.mem_req_valid, mem0.mem_we, mem0.mem_wstrb,
                        bus_err0}), 32'h0);
    chk("rst_inst", cpu0.Instruction, 32'h0);
    chk("rst_rdata", cpu0.Read_data, 32'h0);
    chk("rst_maddr", mem0.mem_addr, 32'h0);
    chk("rst_mwdata", mem0.mem_wdata, 32'h0);
    chk("rst_errcnt", err_cnt0, 32'h0);
    rst = 1'b1;

    // Fetch, 4-cycle latency with immediate memory
    cpu0.PC = 32'h100; cpu0.Inst_Req_Valid = 1; cpu0.Inst_Ready = 1;
    mem0.mem_req_ready = 1; rsp_word = 32'h0000_0013;
    step();  // E1
    chk("fetch_rdy", 32'(cpu0.Inst_Req_Ready), 32'h1);
    step();  // E2
    cpu0.Inst_Req_Valid = 0;
    chk("fetch_rdy_1cyc", 32'(cpu0.Inst_Req_Ready), 32'h0);
    chk("fetch_mreq", 32'({mem0.mem_req_valid, mem0.mem_we}), 32'h2);
    chk("fetch_maddr", mem0.mem_addr, 32'h100);
    step();  // E3
    chk("fetch_early", 32'(cpu0.Inst_Valid), 32'h0);
    step();  // E4
    chk("fetch_lat4", 32'(cpu0.Inst_Valid), 32'h1);
    chk("fetch_inst", cpu0.Instruction, 32'h0000_0013);
    step();
    chk("fetch_done", 32'(cpu0.Inst_Valid), 32'h0);

    // Store; MemRead also high to show read+write counts as a write
    cpu0.Address = 32'h200; cpu0.Write_data = 32'hDEAD_BEEF; cpu0.Write_strb = 4'b0011;
    cpu0.MemWrite = 1; cpu0.MemRead = 1; cpu0.Read_data_Ready = 1;
    step();
    chk("st_rdy", 32'({cpu0.Mem_Req_Ready, cpu0.Inst_Req_Ready}), 32'h2);
    step();
    cpu0.MemWrite = 0; cpu0.MemRead = 0;
    chk("st_mreq", 32'({mem0.mem_req_valid, mem0.mem_we, mem0.mem_wstrb}), 32'h33);
    chk("st_mwdata", mem0.mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("st_wrcnt", 32'(wr_cnt), 32'h1);
    chk("st_waddr", wr_addr, 32'h200);
    chk("st_wdata", wr_data, 32'hDEAD_BEEF);
    chk("st_wstrb", 32'(wr_strb), 32'h3);
    for (int i = 0; i < 3; i++) begin
      chk("st_no_rsp", 32'({cpu0.Read_data_Valid, cpu0.Inst_Valid, mem0.mem_req_valid}), 32'h0);
      step();
    end

    // Contention: load wins, fetch follows
    cpu0.Address = 32'h300; cpu0.MemRead = 1; cpu0.PC = 32'h104; cpu0.Inst_Req_Valid = 1;
    rsp_word = 32'hA5A5_0001;
    step();  // E1
    chk("ct_load_first", 32'({cpu0.Mem_Req_Ready, cpu0.Inst_Req_Ready}), 32'h2);
    step();  // E2
    cpu0.MemRead = 0;
    chk("ct_load_addr", mem0.mem_addr, 32'h300);
    step(2); // E4
    chk("ct_load_vld", 32'({cpu0.Read_data_Valid, cpu0.Inst_Valid}), 32'h2);
    chk("ct_load_data", cpu0.Read_data, 32'hA5A5_0001);
    rsp_word = 32'h0000_0093;
    step();  // E5
    chk("ct_stall", 32'({cpu0.Read_data_Valid, cpu0.Inst_Req_Ready}), 32'h0);
    step();  // E6
    chk("ct_fetch_rdy", 32'({cpu0.Mem_Req_Ready, cpu0.Inst_Req_Ready}), 32'h1);
    step();  // E7
    cpu0.Inst_Req_Valid = 0;
    chk("ct_fetch_addr", mem0.mem_addr, 32'h104);
    step(2); // E9
    chk("ct_fetch_vld", 32'(cpu0.Inst_Valid), 32'h1);
    chk("ct_fetch_inst", cpu0.Instruction, 32'h0000_0093);
    step();

    // Backpressure on both sides
    cpu0.Address = 32'h400; cpu0.MemRead = 1; cpu0.Read_data_Ready = 0;
    mem0.mem_req_ready = 0; rsp_word = 32'hCAFE_F00D;
    mem_hs = 0; cpu_rd_hs = 0;
    step(2);
    cpu0.MemRead = 0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_mreq_hold", 32'({mem0.mem_req_valid, mem0.mem_we}), 32'h2);
      chk("bp_maddr_hold", mem0.mem_addr, 32'h400);
      step();
    end
    mem0.mem_req_ready = 1;
    step();
    mem0.mem_req_ready = 0;
    chk("bp_mreq_drop", 32'(mem0.mem_req_valid), 32'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rd_hold", 32'(cpu0.Read_data_Valid), 32'h1);
      chk("bp_rdata_hold", cpu0.Read_data, 32'hCAFE_F00D);
      step();
    end
    cpu0.Read_data_Ready = 1;
    step();
    chk("bp_rd_done", 32'(cpu0.Read_data_Valid), 32'h0);
    chk("bp_mem_hs", 32'(mem_hs), 32'h1);
    chk("bp_cpu_hs", 32'(cpu_rd_hs), 32'h1);
    chk("bp_no_err", 32'({bus_err0}), 32'h0);
    mem0.mem_req_ready = 1;

    // Timeout on the MEM_LAT_MAX=8 instance
    cpu1.Address = 32'h500; cpu1.MemRead = 1;
    step();
    chk("to_rdy", 32'(cpu1.Mem_Req_Ready), 32'h1);
    step();
    cpu1.MemRead = 0;
    n = 2;
    while (!cpu1.Read_data_Valid && n < 30) begin
      step();
      n++;
    end
    chk("to_latency", 32'(n), 32'd10);
    chk("to_data", cpu1.Read_data, 32'h0);
    chk("to_buserr", 32'(bus_err1), 32'h1);
    chk("to_errcnt", err_cnt1, 32'h1);
    cpu1.Read_data_Ready = 1;
    step();
    chk("to_sticky", 32'({bus_err1, cpu1.Read_data_Valid}), 32'h2);

    // Reset while waiting in MRSP, then a late response
    rsp_en = 0;
    cpu0.Address = 32'h600; cpu0.MemRead = 1;
    step(2);
    cpu0.MemRead = 0;
    step(2);
    rst = 1'b0;
    #1;
    chk("mr_rst_ctl", 32'({cpu0.Inst_Req_Ready, cpu0.Mem_Req_Ready, cpu0.Inst_Valid,
                           cpu0.Read_data_Valid, mem0.mem_req_valid, mem0.mem_we,
                           mem0.mem_wstrb}), 32'h0);
    chk("mr_rst_maddr", mem0.mem_addr, 32'h0);
    chk("mr_rst_rdata", cpu0.Read_data, 32'h0);
    chk("mr_rst_err8", 32'({bus_err1}), 32'h0);
    chk("mr_rst_cnt8", err_cnt1, 32'h0);
    step();
    rst = 1'b1;
    step();
    mem0.mem_rsp_valid = 1; mem0.mem_rdata = 32'h1234_5678;
    step();
    mem0.mem_rsp_valid = 0;
    step(2);
    chk("late_rsp_vld", 32'({cpu0.Read_data_Valid, cpu0.Inst_Valid}), 32'h0);
    chk("late_rsp_data", cpu0.Read_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
